// File: rtl/lsu_pkg.sv
// Shared types, func3 encodings, error codes and legality helpers for the LSU memory initiator.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] ERR_NONE       = 3'b000;
    localparam logic [2:0] ERR_LD_MISALIGN = 3'b001;
    localparam logic [2:0] ERR_ST_MISALIGN = 3'b010;
    localparam logic [2:0] ERR_ILLEGAL_F3 = 3'b011;
    localparam logic [2:0] ERR_TIMEOUT    = 3'b100;

    function automatic logic is_legal_func3(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Size lives in func3[1:0] for every legal encoding: 01 halfword, 10 word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the CPU pipeline and the data-memory controller.
// Optional alignment trapping is enabled by defining MISALIGN_TRAP_EN.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_WIDTH       = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_store,
    input  logic [2:0]               req_func3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [RD_WIDTH-1:0]      req_rd,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic [RD_WIDTH-1:0]      resp_rd,
    output logic                     resp_err,
    output logic [2:0]               resp_err_code,
    output logic                     mem_read_En,
    output logic                     mem_write_En,
    output logic [2:0]               mem_func3,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out,
    input  logic                     mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t                     r_state;
    logic                       r_is_store;
    logic [2:0]                 r_func3;
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [RD_WIDTH-1:0]        r_rd;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_req_ready;
    logic                       r_resp_valid;
    logic [DATA_WIDTH-1:0]      r_resp_rdata;
    logic [RD_WIDTH-1:0]        r_resp_rd;
    logic                       r_resp_err;
    logic [2:0]                 r_resp_err_code;

    logic                       w_legal;
    logic                       w_misalign;
    logic [CNT_W-1:0]           w_cnt_nxt;

    assign w_legal   = is_legal_func3(req_is_store, req_func3);
    assign w_cnt_nxt = r_cnt + CNT_W'(1);
`ifdef MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(req_func3, req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Enables follow mem_ready combinationally so the pulse lands on the cycle the controller is idle.
    assign mem_read_En  = (r_state == ST_ISSUE) && !r_is_store && mem_ready;
    assign mem_write_En = (r_state == ST_ISSUE) &&  r_is_store && mem_ready;
    assign mem_func3    = r_func3;
    assign mem_address  = r_addr;
    assign mem_data_in  = r_wdata;

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_rd       = r_resp_rd;
    assign resp_err      = r_resp_err;
    assign resp_err_code = r_resp_err_code;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state         <= ST_IDLE;
            r_is_store      <= 1'b0;
            r_func3         <= 3'b000;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_rd            <= '0;
            r_cnt           <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_rd       <= '0;
            r_resp_err      <= 1'b0;
            r_resp_err_code <= ERR_NONE;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_is_store <= req_is_store;
                        r_func3    <= req_func3;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rd       <= req_rd;
                        r_req_ready <= 1'b0;
                        if (!w_legal || w_misalign) begin
                            // Rejected requests skip the memory and respond straight away.
                            r_state         <= ST_RESP;
                            r_resp_valid    <= 1'b1;
                            r_resp_rdata    <= '0;
                            r_resp_rd       <= req_rd;
                            r_resp_err      <= 1'b1;
                            r_resp_err_code <= !w_legal ? ERR_ILLEGAL_F3 :
                                               (req_is_store ? ERR_ST_MISALIGN : ERR_LD_MISALIGN);
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        r_state         <= ST_RESP;
                        r_resp_valid    <= 1'b1;
                        r_resp_rdata    <= r_is_store ? '0 : mem_data_out;
                        r_resp_rd       <= r_rd;
                        r_resp_err      <= 1'b0;
                        r_resp_err_code <= ERR_NONE;
                    end else if (w_cnt_nxt == TO_VAL) begin
                        r_state         <= ST_RESP;
                        r_resp_valid    <= 1'b1;
                        r_resp_rdata    <= '0;
                        r_resp_rd       <= r_rd;
                        r_resp_err      <= 1'b1;
                        r_resp_err_code <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases plus randomized requests against a
// request-level reference model; honours MISALIGN_TRAP_EN when the design is built with it.
module tb_lsu_mem_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 8;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk;
    logic          rstN;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [2:0]    req_func3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [RW-1:0] req_rd;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic [RW-1:0] resp_rd;
    logic          resp_err;
    logic [2:0]    resp_err_code;
    logic          mem_read_En;
    logic          mem_write_En;
    logic [2:0]    mem_func3;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_initiator #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstN(rstN),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_err(resp_err), .resp_err_code(resp_err_code),
        .mem_read_En(mem_read_En), .mem_write_En(mem_write_En), .mem_func3(mem_func3),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One request, with the bench acting as the memory controller.
    // stall: cycles the controller stays busy before issue; n_low: busy cycles after issue.
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [RW-1:0] rd, input int stall, input int n_low,
                           input logic [DW-1:0] mdata);
        logic       legal, mis, issue, got;
        logic [2:0] e_code;
        logic [DW-1:0] e_rdata;
        int         e_lat, lat, rd_p, wr_p, low_left, sz;
        logic [DW-1:0] o_rdata;
        logic [RW-1:0] o_rd;
        logic       o_err;
        logic [2:0] o_code;

        // Reference model: outcome from the architectural rules alone.
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        mis   = TRAP && legal && ((addr % sz) != 0);
        issue = legal && !mis;
        e_rdata = '0;
        if (!legal) begin
            e_code = 3'd3; e_lat = 1;
        end else if (mis) begin
            e_code = st ? 3'd2 : 3'd1; e_lat = 1;
        end else if (n_low < TO) begin
            e_code = 3'd0; e_lat = stall + n_low + 3;
            e_rdata = st ? '0 : mdata;
        end else begin
            e_code = 3'd4; e_lat = stall + TO + 2;
        end

        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "/req_ready_idle"}, req_ready, 1'b1);

        req_valid = 1'b1; req_is_store = st; req_func3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd; mem_data_out = mdata; mem_ready = 1'b1;
        low_left = 0; got = 1'b0; rd_p = 0; wr_p = 0; lat = -1;
        o_rdata = '0; o_rd = '0; o_err = 1'b0; o_code = 3'd0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            if (cyc > 0) begin
                if (cyc <= stall) mem_ready = 1'b0;
                else if (low_left > 0) begin mem_ready = 1'b0; low_left--; end
                else mem_ready = 1'b1;
            end
            @(negedge clk);
            if (mem_read_En)  rd_p++;
            if (mem_write_En) wr_p++;
            if (mem_read_En || mem_write_En) begin
                low_left = n_low;
                chk({tag, "/mem_func3"},   mem_func3,   f3);
                chk({tag, "/mem_address"}, mem_address, addr);
                chk({tag, "/mem_data_in"}, mem_data_in, wdata);
            end
            if (resp_valid) begin
                got = 1'b1; lat = cyc;
                o_rdata = resp_rdata; o_rd = resp_rd; o_err = resp_err; o_code = resp_err_code;
            end
            @(posedge clk); #1;
            if (cyc == 0) req_valid = 1'b0;
        end
        mem_ready = 1'b1;

        chk({tag, "/resp_seen"},  got, 1'b1);
        chk({tag, "/latency"},    64'(lat), 64'(e_lat));
        chk({tag, "/err_code"},   o_code, e_code);
        chk({tag, "/err"},        o_err, (e_code != 3'd0));
        chk({tag, "/rdata"},      o_rdata, e_rdata);
        chk({tag, "/rd"},         o_rd, rd);
        chk({tag, "/rd_pulses"},  64'(rd_p), (issue && !st) ? 64'd1 : 64'd0);
        chk({tag, "/wr_pulses"},  64'(wr_p), (issue &&  st) ? 64'd1 : 64'd0);
        chk({tag, "/resp_one_cycle"}, resp_valid, 1'b0);
        chk({tag, "/ready_after"},    req_ready, 1'b1);
    endtask

    initial begin
        int seen;
        rstN = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_func3 = 3'd0;
        req_addr = '0; req_wdata = '0; req_rd = '0; mem_data_out = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/req_ready",   req_ready, 1'b1);
        chk("reset/resp_valid",  resp_valid, 1'b0);
        chk("reset/read_En",     mem_read_En, 1'b0);
        chk("reset/write_En",    mem_write_En, 1'b0);
        chk("reset/mem_address", mem_address, 32'd0);
        chk("reset/resp_err",    resp_err, 1'b0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;

        run_req("lw_basic",   1'b0, 3'b010, 32'h100, 32'h0,  5'd7,  0, 4,  32'hDEADBEEF);
        run_req("sb_basic",   1'b1, 3'b000, 32'h203, 32'h55, 5'd2,  0, 1,  32'h12345678);
        run_req("lh_mis",     1'b0, 3'b001, 32'h101, 32'h0,  5'd9,  0, 2,  32'hFFFF8001);
        run_req("ld_f3_011",  1'b0, 3'b011, 32'h200, 32'h0,  5'd4,  0, 0,  32'h1);
        run_req("sw_mis",     1'b1, 3'b010, 32'h102, 32'hA5, 5'd1,  0, 0,  32'h0);
        run_req("st_f3_100",  1'b1, 3'b100, 32'h300, 32'h1,  5'd3,  0, 0,  32'h0);
        run_req("lw_timeout", 1'b0, 3'b010, 32'h400, 32'h0,  5'd11, 0, 30, 32'hCAFEF00D);
        run_req("lw_edge_ok", 1'b0, 3'b010, 32'h404, 32'h0,  5'd12, 0, TO-1, 32'h0BADCAFE);
        run_req("lbu_stall",  1'b0, 3'b100, 32'h405, 32'h0,  5'd13, 2, 1,  32'h000000AB);

        // Asynchronous reset while waiting on memory.
        req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h40;
        req_rd = 5'd3; mem_ready = 1'b1; mem_data_out = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst/issue_pulse", mem_read_En, 1'b1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("rst/read_En",    mem_read_En, 1'b0);
        chk("rst/write_En",   mem_write_En, 1'b0);
        chk("rst/req_ready",  req_ready, 1'b1);
        chk("rst/resp_valid", resp_valid, 1'b0);
        @(posedge clk); #3;
        rstN = 1'b1; mem_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rst/no_resp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run_req("lw_after_rst", 1'b0, 3'b010, 32'h40, 32'h0, 5'd3, 0, 2, 32'h13579BDF);

        for (int k = 0; k < 40; k++) begin
            logic          st;
            logic [2:0]    f3;
            logic [AW-1:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            run_req($sformatf("rand%0d", k), st, f3, a, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2), $urandom_range(0, 11), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
